// File: rtl/spm_port_arbiter_if.sv
// Bundle of the two requester ports and the single SPM port served by spm_port_arbiter.
// The arbiter binds to the slave modport; requesters (or a bench) drive through master.
interface spm_port_arbiter_if;
  logic        m0_req;
  logic        m0_rw;
  logic [11:0] m0_addr;
  logic [31:0] m0_wr_data;
  logic        m0_gnt;
  logic        m0_rdy;
  logic [31:0] m0_rd_data;

  logic        m1_req;
  logic        m1_rw;
  logic [11:0] m1_addr;
  logic [31:0] m1_wr_data;
  logic        m1_gnt;
  logic        m1_rdy;
  logic [31:0] m1_rd_data;

  logic [11:0] spm_addr;
  logic        spm_as_;
  logic        spm_rw;
  logic [31:0] spm_wr_data;
  logic [31:0] spm_rd_data;

  modport slave (
    input  m0_req, m0_rw, m0_addr, m0_wr_data,
    output m0_gnt, m0_rdy, m0_rd_data,
    input  m1_req, m1_rw, m1_addr, m1_wr_data,
    output m1_gnt, m1_rdy, m1_rd_data,
    output spm_addr, spm_as_, spm_rw, spm_wr_data,
    input  spm_rd_data
  );

  modport master (
    output m0_req, m0_rw, m0_addr, m0_wr_data,
    input  m0_gnt, m0_rdy, m0_rd_data,
    output m1_req, m1_rw, m1_addr, m1_wr_data,
    input  m1_gnt, m1_rdy, m1_rd_data,
    input  spm_addr, spm_as_, spm_rw, spm_wr_data,
    output spm_rd_data
  );
endinterface

// File: rtl/spm_port_arbiter.sv
// Two-master arbiter for one scratchpad port: m0 has priority, m1 is promoted
// after STARVE_LIMIT consecutive denied cycles. Grants are combinational, rdy follows one cycle later.
module spm_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              reset,
  spm_port_arbiter_if.slave bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       pend_valid_q, pend_valid_d;
  logic       pend_owner_q, pend_owner_d;   // 1 = m1 owns the access in flight
  logic       pend_rw_q, pend_rw_d;
  logic       starve;
  logic       gnt0, gnt1;

  always_comb begin
    starve = (wait_cnt_q == LIMIT);
    gnt1   = !reset && bus.m1_req && (!bus.m0_req || starve);
    gnt0   = !reset && bus.m0_req && !gnt1;
  end

  always_comb begin
    wait_cnt_d   = wait_cnt_q;
    pend_valid_d = gnt0 || gnt1;
    pend_owner_d = gnt1;
    pend_rw_d    = gnt1 ? bus.m1_rw : bus.m0_rw;
    if (!bus.m1_req || gnt1) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q < LIMIT) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q   <= 4'd0;
      pend_valid_q <= 1'b0;
      pend_owner_q <= 1'b0;
      pend_rw_q    <= 1'b1;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_owner_q <= pend_owner_d;
      pend_rw_q    <= pend_rw_d;
    end
  end

  // SPM port mux: idle values whenever nothing is granted
  always_comb begin
    bus.m0_gnt      = gnt0;
    bus.m1_gnt      = gnt1;
    bus.spm_as_     = 1'b1;
    bus.spm_rw      = 1'b1;
    bus.spm_addr    = 12'd0;
    bus.spm_wr_data = 32'd0;
    if (gnt1) begin
      bus.spm_as_     = 1'b0;
      bus.spm_rw      = bus.m1_rw;
      bus.spm_addr    = bus.m1_addr;
      bus.spm_wr_data = bus.m1_wr_data;
    end else if (gnt0) begin
      bus.spm_as_     = 1'b0;
      bus.spm_rw      = bus.m0_rw;
      bus.spm_addr    = bus.m0_addr;
      bus.spm_wr_data = bus.m0_wr_data;
    end
  end

  // Reset masks rdy so an access granted just before reset never completes
  always_comb begin
    bus.m0_rdy     = !reset && pend_valid_q && !pend_owner_q;
    bus.m1_rdy     = !reset && pend_valid_q && pend_owner_q;
    bus.m0_rd_data = (bus.m0_rdy && pend_rw_q) ? bus.spm_rd_data : 32'd0;
    bus.m1_rd_data = (bus.m1_rdy && pend_rw_q) ? bus.spm_rd_data : 32'd0;
  end

endmodule

// File: tb/tb_spm_port_arbiter.sv
// Directed bench for spm_port_arbiter: inputs change 1ns after each rising edge,
// outputs are compared 2ns later, well before the next edge.
module tb_spm_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  spm_port_arbiter_if bus ();

  spm_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_reqs();
    bus.m0_req = 1'b0; bus.m0_rw = 1'b1; bus.m0_addr = 12'd0; bus.m0_wr_data = 32'd0;
    bus.m1_req = 1'b0; bus.m1_rw = 1'b1; bus.m1_addr = 12'd0; bus.m1_wr_data = 32'd0;
  endtask

  task automatic check_idle_port(input string tag);
    check({tag, ".as_"},  {31'd0, bus.spm_as_}, 32'd1);
    check({tag, ".rw"},   {31'd0, bus.spm_rw},  32'd1);
    check({tag, ".addr"}, {20'd0, bus.spm_addr}, 32'd0);
    check({tag, ".wd"},   bus.spm_wr_data, 32'd0);
  endtask

  // Both masters request every cycle; m1 is expected only where exp_m1 has a 1.
  task automatic contend(input string tag, input int n, input logic [15:0] exp_m1, input int prev_owner);
    int prev;
    prev = prev_owner;
    for (int i = 0; i < n; i++) begin
      bus.m0_req = 1'b1; bus.m0_rw = 1'b1; bus.m0_addr = 12'h100 + 12'(i);
      bus.m1_req = 1'b1; bus.m1_rw = 1'b1; bus.m1_addr = 12'h200 + 12'(i);
      bus.spm_rd_data = 32'hA000_0000 + 32'(i);
      #2;
      check($sformatf("%s[%0d].m1_gnt", tag, i), {31'd0, bus.m1_gnt}, {31'd0, exp_m1[i]});
      check($sformatf("%s[%0d].m0_gnt", tag, i), {31'd0, bus.m0_gnt}, {31'd0, ~exp_m1[i]});
      check($sformatf("%s[%0d].addr", tag, i), {20'd0, bus.spm_addr},
            exp_m1[i] ? 32'h200 + 32'(i) : 32'h100 + 32'(i));
      check($sformatf("%s[%0d].m0_rdy", tag, i), {31'd0, bus.m0_rdy}, (prev == 0) ? 32'd1 : 32'd0);
      check($sformatf("%s[%0d].m1_rdy", tag, i), {31'd0, bus.m1_rdy}, (prev == 1) ? 32'd1 : 32'd0);
      $display("%s[%0d] m0_gnt=%0b m1_gnt=%0b", tag, i, bus.m0_gnt, bus.m1_gnt);
      prev = exp_m1[i] ? 1 : 0;
      next_cycle();
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_reqs();
    bus.spm_rd_data = 32'hCAFE_F00D;

    // Requests during reset are ignored
    bus.m0_req = 1'b1; bus.m1_req = 1'b1;
    #2;
    check("rst.m0_gnt", {31'd0, bus.m0_gnt}, 32'd0);
    check("rst.m1_gnt", {31'd0, bus.m1_gnt}, 32'd0);
    check("rst.m0_rdy", {31'd0, bus.m0_rdy}, 32'd0);
    check("rst.m1_rdy", {31'd0, bus.m1_rdy}, 32'd0);
    check("rst.m0_rd",  bus.m0_rd_data, 32'd0);
    check_idle_port("rst");
    $display("reset cycle checked");
    next_cycle();
    next_cycle();
    reset = 1'b0;
    idle_reqs();
    #2;
    check("post_rst.m0_rdy", {31'd0, bus.m0_rdy}, 32'd0);
    check("post_rst.m1_rdy", {31'd0, bus.m1_rdy}, 32'd0);
    check_idle_port("post_rst");
    $display("post-reset idle cycle checked");
    next_cycle();

    // m0 read 0x010
    bus.m0_req = 1'b1; bus.m0_rw = 1'b1; bus.m0_addr = 12'h010;
    #2;
    check("rd0.m0_gnt", {31'd0, bus.m0_gnt}, 32'd1);
    check("rd0.m1_gnt", {31'd0, bus.m1_gnt}, 32'd0);
    check("rd0.as_",    {31'd0, bus.spm_as_}, 32'd0);
    check("rd0.rw",     {31'd0, bus.spm_rw}, 32'd1);
    check("rd0.addr",   {20'd0, bus.spm_addr}, 32'h010);
    $display("m0 read 0x010 granted=%0b", bus.m0_gnt);
    next_cycle();
    idle_reqs();
    bus.m0_addr = 12'h555;
    bus.spm_rd_data = 32'hDEAD_BEEF;
    #2;
    check("rd0.m0_rdy", {31'd0, bus.m0_rdy}, 32'd1);
    check("rd0.m0_rd",  bus.m0_rd_data, 32'hDEAD_BEEF);
    check("rd0.m1_rdy", {31'd0, bus.m1_rdy}, 32'd0);
    check("rd0.m1_rd",  bus.m1_rd_data, 32'd0);
    check_idle_port("rd0.idle");
    $display("m0 read complete data=0x%08h", bus.m0_rd_data);
    next_cycle();

    // m1 write 0xFFF
    bus.m1_req = 1'b1; bus.m1_rw = 1'b0; bus.m1_addr = 12'hFFF; bus.m1_wr_data = 32'h1234_5678;
    #2;
    check("wr1.m1_gnt", {31'd0, bus.m1_gnt}, 32'd1);
    check("wr1.m0_gnt", {31'd0, bus.m0_gnt}, 32'd0);
    check("wr1.as_",    {31'd0, bus.spm_as_}, 32'd0);
    check("wr1.rw",     {31'd0, bus.spm_rw}, 32'd0);
    check("wr1.addr",   {20'd0, bus.spm_addr}, 32'hFFF);
    check("wr1.wd",     bus.spm_wr_data, 32'h1234_5678);
    check("wr1.m0_rdy", {31'd0, bus.m0_rdy}, 32'd0);
    $display("m1 write 0xFFF granted=%0b", bus.m1_gnt);
    next_cycle();
    idle_reqs();
    #2;
    check("wr1.m1_rdy", {31'd0, bus.m1_rdy}, 32'd1);
    check("wr1.m1_rd",  bus.m1_rd_data, 32'd0);
    check("wr1.m0_rd",  bus.m0_rd_data, 32'd0);
    $display("m1 write complete rdy=%0b", bus.m1_rdy);
    next_cycle();

    // m0 write passes its data to the port
    bus.m0_req = 1'b1; bus.m0_rw = 1'b0; bus.m0_addr = 12'h0A5; bus.m0_wr_data = 32'h0BAD_CAFE;
    #2;
    check("wr0.wd",   bus.spm_wr_data, 32'h0BAD_CAFE);
    check("wr0.addr", {20'd0, bus.spm_addr}, 32'h0A5);
    $display("m0 write 0x0A5 granted=%0b", bus.m0_gnt);
    next_cycle();

    // m0 read then m1 read back to back; new m1 grant overlaps with m0 completion
    bus.m0_req = 1'b1; bus.m0_rw = 1'b1; bus.m0_addr = 12'h020;
    #2;
    check("b2b.m0_rdy_wr", {31'd0, bus.m0_rdy}, 32'd1);
    check("b2b.m0_rd_wr",  bus.m0_rd_data, 32'd0);
    check("b2b.m0_gnt",    {31'd0, bus.m0_gnt}, 32'd1);
    next_cycle();
    idle_reqs();
    bus.m1_req = 1'b1; bus.m1_rw = 1'b1; bus.m1_addr = 12'h030;
    bus.spm_rd_data = 32'h1111_1111;
    #2;
    check("b2b.m1_gnt",  {31'd0, bus.m1_gnt}, 32'd1);
    check("b2b.m0_rdy",  {31'd0, bus.m0_rdy}, 32'd1);
    check("b2b.m0_rd",   bus.m0_rd_data, 32'h1111_1111);
    check("b2b.m1_rd0",  bus.m1_rd_data, 32'd0);
    $display("b2b m0 done data=0x%08h, m1 granted=%0b", bus.m0_rd_data, bus.m1_gnt);
    next_cycle();
    idle_reqs();
    bus.spm_rd_data = 32'h2222_2222;
    #2;
    check("b2b.m1_rdy", {31'd0, bus.m1_rdy}, 32'd1);
    check("b2b.m1_rd",  bus.m1_rd_data, 32'h2222_2222);
    check("b2b.m0_rd",  bus.m0_rd_data, 32'd0);
    $display("b2b m1 done data=0x%08h", bus.m1_rd_data);
    next_cycle();

    // Continuous contention: m0 x4, m1, m0 x4, m1
    contend("starve", 10, 16'b0000_0010_0001_0000, 2);
    idle_reqs();
    #2;
    check("starve.tail_m1_rdy", {31'd0, bus.m1_rdy}, 32'd1);
    next_cycle();

    // m1 denied 3 cycles, drops for one cycle, then needs 4 fresh denials
    contend("drop", 3, 16'b0000_0000_0000_0000, 2);
    idle_reqs();
    next_cycle();
    contend("rearm", 5, 16'b0000_0000_0001_0000, 2);
    idle_reqs();
    next_cycle();

    // Reset in the cycle after an m0 grant cancels its completion and the wait count
    contend("pre_rst", 3, 16'b0000_0000_0000_0000, 2);
    reset = 1'b1;
    idle_reqs();
    bus.m1_req = 1'b1;
    #2;
    check("rst2.m0_rdy", {31'd0, bus.m0_rdy}, 32'd0);
    check("rst2.m0_rd",  bus.m0_rd_data, 32'd0);
    check("rst2.m1_gnt", {31'd0, bus.m1_gnt}, 32'd0);
    check_idle_port("rst2");
    $display("reset after m0 grant: m0_rdy=%0b", bus.m0_rdy);
    next_cycle();
    reset = 1'b0;
    idle_reqs();
    #2;
    check("rst2.after_rdy", {31'd0, bus.m0_rdy}, 32'd0);
    idle_reqs();
    // First cycle out of reset can grant; wait count restarts from 0
    contend("post_rst2", 5, 16'b0000_0000_0001_0000, 2);
    idle_reqs();
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
